// File: rtl/fsm_dispatcher_if.sv
// Handshake bundle between the Control Unit dispatcher and its environment:
// run/fetch control, one-hot unit select/start/done, and status/trap outputs.
interface fsm_dispatcher_if #(
    parameter int N_UNITS = 4,
    parameter int CNT_W   = 32
);
    logic               run;
    logic               mem_ready;
    logic [N_UNITS-1:0] unit_sel;
    logic [N_UNITS-1:0] unit_done;
    logic               fetch_req;
    logic               load_ir;
    logic [N_UNITS-1:0] start;
    logic               busy;
    logic [CNT_W-1:0]   retired;
    logic               illegal;
    logic               timeout;

    // Environment side: drives requests, observes the dispatcher.
    modport master (
        output run, mem_ready, unit_sel, unit_done,
        input  fetch_req, load_ir, start, busy, retired, illegal, timeout
    );

    // Dispatcher side.
    modport slave (
        input  run, mem_ready, unit_sel, unit_done,
        output fetch_req, load_ir, start, busy, retired, illegal, timeout
    );
endinterface

// File: rtl/fsm_dispatcher.sv
// Top-level Control Unit sequencer: fetch, latch the instruction register,
// start exactly one sub-FSM, wait for its done pulse, retire and repeat.
// Bad unit selection or a unit that never finishes lands in an absorbing
// TRAP state with a sticky flag; only reset leaves it.
module fsm_dispatcher #(
    parameter int N_UNITS = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    fsm_dispatcher_if.slave   bus
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_DISPATCH = 3'd3,
        S_WAIT     = 3'd4,
        S_RETIRE   = 3'd5,
        S_TRAP     = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [N_UNITS-1:0]   active_q, active_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic                 fetch_req_q;
    logic                 load_ir_q;
    logic                 busy_q;
    logic [N_UNITS-1:0]   start_s;

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [N_UNITS-1:0] v);
        return (v != '0) && ((v & (v - N_UNITS'(1))) == '0);
    endfunction

    // Next-state, datapath updates and the combinational start pulse.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        wcnt_d    = wcnt_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        start_s   = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                // Memory latency is unbounded; no timeout while fetching.
                if (bus.mem_ready) begin
                    state_d = S_LATCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_LATCH: begin
                state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                // unit_sel is only trusted here, one cycle after the IR load.
                if (is_onehot(bus.unit_sel)) begin
                    start_s  = bus.unit_sel;
                    active_d = bus.unit_sel;
                    wcnt_d   = '0;
                    state_d  = S_WAIT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WAIT: begin
                // Done is checked first so it beats a simultaneous timeout;
                // done pulses from other units are masked off.
                if ((bus.unit_done & active_q) != '0) begin
                    state_d = S_RETIRE;
                end else if (wcnt_q == WCNT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_RETIRE: begin
                // Counter wraps silently.
                retired_d = retired_q + CNT_W'(1);
                if (bus.run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                // Corrupted encoding: park safely, never resume on its own.
                state_d = S_TRAP;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            active_q  <= '0;
            wcnt_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            wcnt_q    <= wcnt_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Registered state decodes, so these outputs have no path from inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_req_q <= 1'b0;
            load_ir_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fetch_req_q <= (state_d == S_FETCH);
            load_ir_q   <= (state_d == S_LATCH);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_TRAP);
        end
    end

    assign bus.fetch_req = fetch_req_q;
    assign bus.load_ir   = load_ir_q;
    assign bus.busy      = busy_q;
    assign bus.start     = start_s;
    assign bus.retired   = retired_q;
    assign bus.illegal   = illegal_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_fsm_dispatcher.sv
// Self-checking bench for fsm_dispatcher (N_UNITS=4, TIMEOUT=16, CNT_W=4).
// An instruction-level model builds the expected per-cycle timeline from
// fetch delay, unit select and done delay; a table of scenarios checks
// end results, hand sequences cover run drop and counter wrap, and a random
// phase exercises mixed traffic.
module tb_fsm_dispatcher;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fsm_dispatcher_if #(.N_UNITS(4), .CNT_W(4)) bus_if ();

    fsm_dispatcher #(.N_UNITS(4), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int         m_retired;
    bit         m_illegal;
    bit         m_timeout;
    bit         trapped;
    logic [3:0] seen_start;

    typedef struct {
        int         fd;
        logic [3:0] sel;
        int         dd;
        logic [3:0] exp_start;
        logic [3:0] exp_ret;
        logic       exp_ill;
        logic       exp_to;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic m, input logic [3:0] s, input logic [3:0] d);
        @(posedge clk);
        #1;
        bus_if.run       = r;
        bus_if.mem_ready = m;
        bus_if.unit_sel  = s;
        bus_if.unit_done = d;
        #1;
    endtask

    task automatic chk_cycle(input string w, input logic f, input logic l,
                             input logic [3:0] st, input logic b);
        chk({w, ".fetch_req"}, bus_if.fetch_req, f);
        chk({w, ".load_ir"},   bus_if.load_ir,   l);
        chk({w, ".start"},     bus_if.start,     st);
        chk({w, ".busy"},      bus_if.busy,      b);
        chk({w, ".retired"},   bus_if.retired,   m_retired);
        chk({w, ".illegal"},   bus_if.illegal,   m_illegal);
        chk({w, ".timeout"},   bus_if.timeout,   m_timeout);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset            = 1'b1;
        bus_if.run       = 1'b1;
        bus_if.mem_ready = 1'b1;
        bus_if.unit_sel  = 4'b0001;
        bus_if.unit_done = 4'b0000;
        m_retired = 0;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        #1;
        chk_cycle("reset", 1'b0, 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        bus_if.run       = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.unit_sel  = 4'h0;
        reset            = 1'b0;
    endtask

    // One IDLE cycle with run=1; the following cycle is FETCH.
    task automatic enter_fetch();
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk_cycle("idle_go", 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            step(1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
            chk_cycle("idle", 1'b0, 1'b0, 4'h0, 1'b0);
        end
    endtask

    task automatic trap_cycles();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            chk_cycle("trap", 1'b0, 1'b0, 4'h0, 1'b0);
        end
    endtask

    // One instruction: fd cycles of mem_ready low, unit select sel, done
    // on WAIT cycle dd (dd >= TO means never), run_v held from WAIT onward.
    task automatic instr(input int fd, input logic [3:0] sel, input int dd, input logic run_v);
        logic       onehot;
        logic [3:0] noise;
        trapped = 1'b0;
        for (int i = 0; i <= fd; i++) begin
            step(1'b1, (i == fd), 4'h0, 4'h0);
            chk_cycle("fetch", 1'b1, 1'b0, 4'h0, 1'b1);
        end
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk_cycle("latch", 1'b0, 1'b1, 4'h0, 1'b1);
        step(1'b1, 1'b0, sel, 4'h0);
        onehot = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (sel == (4'b0001 << b)) onehot = 1'b1;
        end
        seen_start = bus_if.start;
        chk_cycle("dispatch", 1'b0, 1'b0, onehot ? sel : 4'h0, 1'b1);
        if (!onehot) begin
            m_illegal = 1'b1;
            trapped   = 1'b1;
            trap_cycles();
            return;
        end
        for (int i = 0; i < TO; i++) begin
            noise = 4'($urandom) & ~sel;
            step(run_v, 1'b0, sel, (i == dd) ? (noise | sel) : noise);
            chk_cycle("wait", 1'b0, 1'b0, 4'h0, 1'b1);
            if (i == dd) break;
        end
        if (dd >= TO) begin
            m_timeout = 1'b1;
            trapped   = 1'b1;
            trap_cycles();
            return;
        end
        step(run_v, 1'b0, 4'h0, 4'h0);
        chk_cycle("retire", 1'b0, 1'b0, 4'h0, 1'b1);
        m_retired = (m_retired + 1) % 16;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rsel;
        int         rdd;
        logic       rrun;

        reset            = 1'b1;
        bus_if.run       = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.unit_sel  = 4'h0;
        bus_if.unit_done = 4'h0;

        //        fd  sel      dd  start    ret    ill   to
        tbl[0] = '{0, 4'b0001,  3, 4'b0001, 4'd1, 1'b0, 1'b0};
        tbl[1] = '{7, 4'b0010,  0, 4'b0010, 4'd1, 1'b0, 1'b0};
        tbl[2] = '{0, 4'b0110,  0, 4'b0000, 4'd0, 1'b1, 1'b0};
        tbl[3] = '{2, 4'b0000,  0, 4'b0000, 4'd0, 1'b1, 1'b0};
        tbl[4] = '{0, 4'b0100, 99, 4'b0100, 4'd0, 1'b0, 1'b1};
        tbl[5] = '{1, 4'b1000, 15, 4'b1000, 4'd1, 1'b0, 1'b0};
        tbl[6] = '{0, 4'b1111,  0, 4'b0000, 4'd0, 1'b1, 1'b0};

        // Table-driven scenarios, each from a fresh reset.
        for (int t = 0; t < 7; t++) begin
            do_reset();
            enter_fetch();
            instr(tbl[t].fd, tbl[t].sel, tbl[t].dd, 1'b0);
            if (!trapped) idle(2);
            chk("tbl_start",   seen_start,      tbl[t].exp_start);
            chk("tbl_retired", bus_if.retired,  tbl[t].exp_ret);
            chk("tbl_illegal", bus_if.illegal,  tbl[t].exp_ill);
            chk("tbl_timeout", bus_if.timeout,  tbl[t].exp_to);
        end

        // run dropped during WAIT: instruction completes, then IDLE.
        do_reset();
        enter_fetch();
        instr(0, 4'b1000, 2, 1'b0);
        idle(5);
        chk("rundrop_retired", bus_if.retired, 4'd1);
        enter_fetch();
        instr(0, 4'b0001, 0, 1'b0);
        idle(1);

        // 16 back-to-back instructions: 4-bit counter wraps to 0.
        do_reset();
        enter_fetch();
        for (int k = 0; k < 16; k++) begin
            instr(0, 4'b0001 << (k % 4), k % 5, (k != 15));
        end
        idle(1);
        chk("wrap_retired", bus_if.retired, 4'd0);
        chk("wrap_illegal", bus_if.illegal, 1'b0);
        chk("wrap_timeout", bus_if.timeout, 1'b0);

        // Random traffic against the model.
        do_reset();
        enter_fetch();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8) rsel = 4'b0001 << $urandom_range(0, 3);
            else                          rsel = 4'($urandom);
            rdd  = $urandom_range(0, 18);
            rrun = ($urandom_range(0, 3) != 0);
            instr($urandom_range(0, 3), rsel, rdd, rrun);
            if (trapped) begin
                do_reset();
                enter_fetch();
            end else if (!rrun) begin
                idle($urandom_range(1, 3));
                enter_fetch();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
